// File: rtl/mem_request_master.sv
// Initiator front end for memory_controller: buffers upstream commands in a FIFO,
// issues one controller transaction at a time, and returns in-order responses.
module mem_request_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_we,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic       mc_read_en,
  output logic       mc_write_en,
  output logic [7:0] mc_addr,
  output logic [7:0] mc_wdata,
  input  logic [7:0] mc_rdata,
  input  logic       mc_ready,
  output logic       busy,
  output logic [15:0] txn_count,
  output logic [7:0] err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TMO_C   = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [16:0]   fifo_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] tmo_q, tmo_d, tmo_inc;
  logic          we_q, we_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [7:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic          rvld_q, rvld_d, rwe_q, rwe_d, rto_q, rto_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [15:0]   txn_q, txn_d;
  logic [7:0]    err_q, err_d;
  logic          full, empty, push, pop;
  logic [16:0]   head;

  assign full      = (cnt_q == DEPTH_C);
  assign empty     = (cnt_q == '0);
  assign cmd_ready = reset & ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state_q == IDLE) & ~empty;
  assign head      = fifo_q[rd_ptr_q];
  assign tmo_inc   = tmo_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    we_d     = we_q;
    rd_en_d  = rd_en_q;
    wr_en_d  = wr_en_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rvld_d   = rvld_q;
    rwe_d    = rwe_q;
    rto_d    = rto_q;
    rdata_d  = rdata_q;
    txn_d    = txn_q;
    err_d    = err_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);

    case (state_q)
      IDLE: if (!empty) begin
        we_d    = head[16];
        addr_d  = head[15:8];
        wdata_d = head[7:0];
        wr_en_d = head[16];
        rd_en_d = ~head[16];
        state_d = ISSUE;
      end
      ISSUE: begin
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A ready arriving on the timeout edge still completes normally.
        if (mc_ready) begin
          rdata_d = we_q ? 8'h00 : mc_rdata;
          rto_d   = 1'b0;
          rwe_d   = we_q;
          rvld_d  = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_C) begin
            rdata_d = 8'h00;
            rto_d   = 1'b1;
            rwe_d   = we_q;
            rvld_d  = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: if (rsp_ready) begin
        rvld_d  = 1'b0;
        txn_d   = txn_q + 16'd1;
        if (rto_q && err_q != 8'hFF) err_d = err_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rvld_q   <= 1'b0;
      rwe_q    <= 1'b0;
      rto_q    <= 1'b0;
      rdata_q  <= 8'h00;
      txn_q    <= 16'h0000;
      err_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvld_q   <= rvld_d;
      rwe_q    <= rwe_d;
      rto_q    <= rto_d;
      rdata_q  <= rdata_d;
      txn_q    <= txn_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {cmd_we, cmd_addr, cmd_wdata};
  end

  assign busy        = ~empty | (state_q != IDLE);
  assign mc_read_en  = rd_en_q;
  assign mc_write_en = wr_en_q;
  assign mc_addr     = addr_q;
  assign mc_wdata    = wdata_q;
  assign rsp_valid   = rvld_q;
  assign rsp_we      = rwe_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_timeout = rto_q;
  assign txn_count   = txn_q;
  assign err_count   = err_q;
endmodule

// File: tb/tb_mem_request_master.sv
// Directed bench for mem_request_master with a small controller model and
// scoreboards for issued commands and returned responses.
module tb_mem_request_master;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [7:0] cmd_addr = 8'h00, cmd_wdata = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_we, rsp_timeout;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       mc_read_en, mc_write_en, mc_ready;
  logic [7:0] mc_addr, mc_wdata, mc_rdata;
  logic       busy;
  logic [15:0] txn_count;
  logic [7:0] err_count;

  int total = 0, bad = 0;
  int issued = 0, rsp_seen = 0;
  logic [16:0] issq[$];
  logic [9:0]  rspq[$];

  // controller model
  logic [7:0] mdl_mem [256];
  int  lat = 0;
  bit  mute = 1'b0;
  logic pend = 1'b0;
  int  ctr = 0;
  logic [7:0] pa = 8'h00;
  logic mr = 1'b0;
  logic [7:0] mrd = 8'h00;
  assign mc_ready = mr;
  assign mc_rdata = mrd;

  mem_request_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .mc_read_en(mc_read_en), .mc_write_en(mc_write_en), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_ready(mc_ready),
    .busy(busy), .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;

  // ready is asserted lat edges after the model first sees the enable
  always @(posedge clk) begin
    if (!reset) begin
      mr <= 1'b0; pend <= 1'b0;
    end else begin
      mr <= 1'b0;
      if (mc_read_en || mc_write_en) begin
        if (mc_write_en) mdl_mem[mc_addr] <= mc_wdata;
        pa <= mc_addr;
        if (lat == 0) begin
          if (!mute) begin mr <= 1'b1; mrd <= mdl_mem[mc_addr]; end
        end else begin
          pend <= 1'b1; ctr <= lat;
        end
      end else if (pend) begin
        if (ctr == 1) begin
          pend <= 1'b0;
          if (!mute) begin mr <= 1'b1; mrd <= mdl_mem[pa]; end
        end else ctr <= ctr - 1;
      end
    end
  end

  // monitors: issue pulses and responses against the scoreboards
  logic prev_en = 1'b0, hold = 1'b0;
  logic [9:0] held = '0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (mc_read_en || mc_write_en) begin
        chk("en_exclusive", {mc_read_en, mc_write_en} != 2'b11, 1);
        chk("en_single_cycle", prev_en, 0);
        chk("issue_expected", issq.size() != 0, 1);
        if (issq.size() != 0)
          chk("issue_cmd", {mc_write_en, mc_addr, mc_wdata}, issq.pop_front());
        issued++;
      end
      prev_en = mc_read_en | mc_write_en;
      if (rsp_valid) begin
        if (hold) chk("rsp_stable", {rsp_we, rsp_rdata, rsp_timeout}, held);
        if (rsp_ready) begin
          chk("rsp_expected", rspq.size() != 0, 1);
          if (rspq.size() != 0)
            chk("rsp_data", {rsp_we, rsp_rdata, rsp_timeout}, rspq.pop_front());
          rsp_seen++;
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held = {rsp_we, rsp_rdata, rsp_timeout};
        end
      end else hold = 1'b0;
    end else begin
      prev_en = 1'b0; hold = 1'b0;
    end
  end

  // called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] erd, input logic eto);
    int n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d;
    while (cmd_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk("accept_bound", n < 500, 1);
    @(posedge clk);
    issq.push_back({we, a, d});
    rspq.push_back({we, erd, eto});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || rsp_valid !== 1'b0) && n < 2000) begin @(negedge clk); n++; end
    chk("idle_bound", n < 2000, 1);
  endtask

  initial begin
    int iss0;
    // reset held with a command offered
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'h66;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_outputs", {mc_read_en, mc_write_en, mc_addr, mc_wdata, rsp_valid, rsp_we,
                          rsp_rdata, rsp_timeout, busy, txn_count, err_count}, 0);
    end
    cmd_valid = 1'b0;
    reset = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);

    // writes, with cycle-exact timing on the first
    send(1'b1, 8'h01, 8'h16, 8'h00, 1'b0);
    chk("t_acc_en", mc_write_en, 0);
    chk("t_acc_busy", busy, 1);
    @(negedge clk);
    chk("t_en_hi", {mc_write_en, mc_read_en, mc_addr, mc_wdata}, {2'b10, 8'h01, 8'h16});
    @(negedge clk);
    chk("t_en_lo", {mc_write_en, rsp_valid}, 0);
    @(negedge clk);
    chk("t_rsp_min_lat", rsp_valid, 1);
    send(1'b1, 8'h02, 8'hAA, 8'h00, 1'b0);
    wait_idle();
    chk("txn_after_writes", txn_count, 2);

    // reads with varying controller latency
    lat = 0;
    send(1'b0, 8'h01, 8'h00, 8'h16, 1'b0);
    lat = 3;
    send(1'b0, 8'h02, 8'h00, 8'hAA, 1'b0);
    wait_idle();
    chk("txn_after_reads", txn_count, 4);
    chk("err_after_reads", err_count, 0);

    // backpressure: 1 in flight + 4 buffered
    lat = 1;
    rsp_ready = 1'b0;
    iss0 = issued;
    send(1'b0, 8'h01, 8'h00, 8'h16, 1'b0);
    send(1'b1, 8'h03, 8'h5C, 8'h00, 1'b0);
    send(1'b0, 8'h03, 8'h00, 8'h5C, 1'b0);
    send(1'b0, 8'h02, 8'h00, 8'hAA, 1'b0);
    send(1'b1, 8'h01, 8'h77, 8'h00, 1'b0);
    chk("bp_full", cmd_ready, 0);
    repeat (8) @(negedge clk);
    chk("bp_one_issued", issued - iss0, 1);
    chk("bp_rsp_held", rsp_valid, 1);
    chk("bp_still_full", cmd_ready, 0);
    rsp_ready = 1'b1;
    wait_idle();
    chk("bp_all_issued", issued - iss0, 5);
    chk("txn_after_bp", txn_count, 9);

    // timeout with exact rise edge
    mute = 1'b1; lat = 0;
    rsp_ready = 1'b0;
    send(1'b0, 8'h10, 8'h00, 8'h00, 1'b1);
    repeat (17) @(negedge clk);
    chk("tmo_not_yet", rsp_valid, 0);
    @(negedge clk);
    chk("tmo_rise", {rsp_valid, rsp_timeout, rsp_rdata}, {2'b11, 8'h00});
    repeat (2) @(negedge clk);
    rsp_ready = 1'b1;
    wait_idle();
    chk("err_one", err_count, 1);
    chk("txn_after_tmo", txn_count, 10);

    // ready on the timeout edge wins
    mute = 1'b0; lat = 15;
    send(1'b0, 8'h02, 8'h00, 8'hAA, 1'b0);
    wait_idle();
    chk("edge_race_err", err_count, 1);

    // saturation of the error counter
    mute = 1'b1; lat = 0;
    for (int i = 0; i < 256; i++) begin
      send(1'b0, 8'(i), 8'h00, 8'h00, 1'b1);
      wait_idle();
    end
    chk("err_sat", err_count, 8'hFF);
    chk("txn_after_sat", txn_count, 16'd267);

    // reset while waiting with 2 commands queued
    send(1'b0, 8'h20, 8'h00, 8'h00, 1'b1);
    send(1'b1, 8'h21, 8'h33, 8'h00, 1'b0);
    send(1'b0, 8'h22, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    issq.delete(); rspq.delete();
    iss0 = issued;
    @(negedge clk);
    chk("mid_rst_outputs", {mc_read_en, mc_write_en, mc_addr, mc_wdata, rsp_valid, rsp_we,
                            rsp_rdata, rsp_timeout, busy, txn_count, err_count}, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    reset = 1'b1; mute = 1'b0;
    @(negedge clk);
    chk("mid_rel_busy", busy, 0);
    chk("mid_rel_ready", cmd_ready, 1);
    repeat (30) @(negedge clk);
    chk("mid_no_issue", issued - iss0, 0);
    chk("mid_no_rsp", rsp_valid, 0);
    chk("mid_counters", {txn_count, err_count}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_request_master.md
# mem_request_master

Initiator-side front end for `memory_controller`. It accepts read/write commands from an upstream client through a valid/ready port and buffers them in a small command FIFO. It issues each command to the controller as a one-cycle enable pulse, then waits for `ready` with a timeout and returns one response per command. It sits between any traffic source (CPU shim, DMA, test sequencer) and `memory_controller`.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 16: WAIT-state clock edges allowed before a transaction is declared timed out; ≥1.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-low; sampled on `clk`.
- `cmd_valid` in 1: upstream command present.
- `cmd_ready` out 1: FIFO can accept; equals `reset & ~full`.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_addr` in 8: target address.
- `cmd_wdata` in 8: write data; ignored for reads.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: upstream accepts response.
- `rsp_we` out 1: echo of the command type.
- `rsp_rdata` out 8: read data; 0 for writes and timeouts.
- `rsp_timeout` out 1: transaction ended by timeout.
- `mc_read_en` out 1: to controller `read_en`.
- `mc_write_en` out 1: to controller `write_en`.
- `mc_addr` out 8: to controller `addr`.
- `mc_wdata` out 8: to controller `data_in`.
- `mc_rdata` in 8: from controller `data_out`.
- `mc_ready` in 1: from controller `ready`.
- `busy` out 1: FIFO non-empty or state ≠ IDLE.
- `txn_count` out 16: completed transactions (timeouts included); wraps from 0xFFFF to 0.
- `err_count` out 8: timed-out transactions; saturates at 0xFF.

## Operation
- **FIFO.** A push occurs on any edge where `cmd_valid & cmd_ready`. Entries hold {we, addr, wdata}. No push while full, even if a pop happens on the same edge. Push and pop on the same edge are both honoured and leave the count unchanged. There is no bypass: a command always lands in the FIFO first.
- **FSM states.** The FSM has four states: IDLE, ISSUE, WAIT, RESP.
  - **IDLE.** If the FIFO is non-empty, pop the head into `mc_addr`, `mc_wdata` and an internal `we` register, then go to ISSUE. Otherwise stay in IDLE.
  - **ISSUE.** Exactly one cycle. `mc_write_en` = `we`, `mc_read_en` = `~we`, never both. `mc_ready` is ignored at the edge that ends ISSUE. The FSM always moves to WAIT and clears the timeout counter.
  - **WAIT.** Both enables are low and `mc_addr`/`mc_wdata` stay stable.
    - At the first edge with `mc_ready`=1: capture `rsp_rdata` = `we ? 0 : mc_rdata`, set `rsp_timeout`=0, go to RESP.
    - Otherwise the counter increments. The edge at which the counter reaches `TIMEOUT_CYCLES` captures `rsp_rdata`=0, sets `rsp_timeout`=1 and goes to RESP.
    - If `mc_ready` is high on that same edge, `mc_ready` wins (no timeout).
  - **RESP.** `rsp_valid`=1 while in RESP; `rsp_we`/`rsp_rdata`/`rsp_timeout` are held stable until the accept edge. On an edge with `rsp_ready`=1:
    - go to IDLE;
    - `txn_count` +1;
    - `err_count` +1 if `rsp_timeout` and below 0xFF.
- `mc_addr`/`mc_wdata` retain their last values after completion.
- **Ordering.** Strictly one outstanding controller transaction. Responses return in command order.

## Timing
- **Reset** (any edge with `reset`=0, including mid-transaction):
  - state → IDLE, FIFO flushed, counters → 0;
  - `mc_read_en`, `mc_write_en`, `mc_addr`, `mc_wdata`, `rsp_valid`, `rsp_we`, `rsp_rdata`, `rsp_timeout`, `busy`, `txn_count`, `err_count` all 0 after the edge;
  - `cmd_ready`=0 while `reset`=0;
  - an abandoned transaction produces no response.
- **Command to enable.** Command accepted at edge E with an empty FIFO and the FSM in IDLE: the enable is high from edge E+1 to E+2.
- **Ready to response.** `mc_ready` sampled high at edge W: `rsp_valid` high from W.
- **Minimum latency.** Enable start to `rsp_valid` is 2 cycles when `mc_ready` is high at the first WAIT edge.
- **Timeout.** `rsp_valid` rises `TIMEOUT_CYCLES` edges after entering WAIT.
- **Back-to-back.** One IDLE cycle sits between a response accept and the next ISSUE. Issue-to-issue spacing is therefore ≥4 cycles.
- **Outputs.** All outputs are registered except `cmd_ready` and `busy`, which are combinational from registered state.

## Test plan
- Reset held 3 cycles with `cmd_valid`=1 → `cmd_ready`=0 throughout, all outputs 0, no enable pulse; after release `cmd_ready`=1.
- Write addr 0x01 data 0x16 (22), then write addr 0x02 data 0xAA → two single-cycle `mc_write_en` pulses with correct `mc_addr`/`mc_wdata`; two responses with `rsp_we`=1, `rsp_rdata`=0; `txn_count`=2.
- Read addr 0x01, then read addr 0x02 against a controller model holding the above → `rsp_rdata` = 0x16 then 0xAA, in order, `rsp_timeout`=0.
- Push 5 commands with `rsp_ready`=0 (`FIFO_DEPTH`=4) → 1 command popped and 4 buffered before `cmd_ready` drops; RESP holds stable; releasing `rsp_ready` drains all 5 in order.
- `mc_ready` tied 0, `TIMEOUT_CYCLES`=16 → `rsp_valid` 16 edges after WAIT entry with `rsp_timeout`=1, `rsp_rdata`=0, `err_count`=1; a 256-timeout run leaves `err_count` at 0xFF.
- `reset` asserted during WAIT with 2 commands queued → enables low, FIFO empty, no `rsp_valid`, `busy`=0, counters 0.
